// File: rtl/regfile_scoreboard.sv
// Parametrised register file for decode/register-read: read-only constant
// registers, optional write-to-read bypass and a per-register pending scoreboard.

module regfile_scoreboard_rdport #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_d_i,
    input  logic             pend_d_i,
    output logic [WIDTH-1:0] data_o,
    output logic             pend_o
);
    logic [WIDTH-1:0] data_q;
    logic             pend_q;

    // A disabled port holds its last result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
            pend_q <= 1'b0;
        end else if (en_i) begin
            data_q <= data_d_i;
            pend_q <= pend_d_i;
        end
    end

    assign data_o = data_q;
    assign pend_o = pend_q;
endmodule

module regfile_scoreboard #(
    parameter  int WIDTH  = 16,
    parameter  int NREGS  = 64,
    parameter  int NRD    = 2,
    parameter  int NCONST = 4,
    parameter  int BYPASS = 1,
    localparam int AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_pend,
    output logic                 stall,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 claim_en,
    input  logic [AW-1:0]        claim_addr,
    output logic [AW:0]          pend_cnt
);
    localparam logic [AW:0] NCONST_W = (AW+1)'(NCONST);
    localparam logic [AW:0] NREGS_W  = (AW+1)'(NREGS);
    localparam bit          BYP      = (BYPASS != 0);

    function automatic logic [WIDTH-1:0] const_val(input int k);
        case (k)
            1:       const_val = WIDTH'(1);
            2:       const_val = {1'b1, {(WIDTH-1){1'b0}}};
            3:       const_val = '1;
            default: const_val = '0;
        endcase
    endfunction

    logic [NREGS-1:0][WIDTH-1:0] regs_q;
    logic [NREGS-1:0]            pend_q;
    logic [AW:0]                 cnt_q, cnt_d;
    logic                        stall_q;

    logic wr_ok, cl_ok, same_addr, pend_set, pend_clr;

    assign wr_ok     = wr_en && ({1'b0, wr_addr} >= NCONST_W) && ({1'b0, wr_addr} < NREGS_W);
    assign cl_ok     = claim_en && ({1'b0, claim_addr} >= NCONST_W) && ({1'b0, claim_addr} < NREGS_W);
    assign same_addr = wr_ok && cl_ok && (wr_addr == claim_addr);
    // A same-address claim beats the write clear, so only an independent write can decrement.
    assign pend_set  = cl_ok && !pend_q[claim_addr];
    assign pend_clr  = wr_ok && pend_q[wr_addr] && !same_addr;
    assign cnt_d     = cnt_q + (AW+1)'(pend_set) - (AW+1)'(pend_clr);

    logic [NRD-1:0][WIDTH-1:0] rdat_d, rdat_q;
    logic [NRD-1:0]            rpend_d, rpend_q;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] a;
        logic          in_rng, hit;
        assign a      = rd_addr[g*AW +: AW];
        assign in_rng = ({1'b0, a} < NREGS_W);
        assign hit    = BYP && wr_ok && (wr_addr == a);
        assign rdat_d[g]  = hit ? wr_data : (in_rng ? regs_q[a] : '0);
        assign rpend_d[g] = !hit && in_rng && pend_q[a];

        regfile_scoreboard_rdport #(.WIDTH(WIDTH)) u_rd (
            .clk      (clk),
            .reset    (reset),
            .en_i     (rd_en[g]),
            .data_d_i (rdat_d[g]),
            .pend_d_i (rpend_d[g]),
            .data_o   (rdat_q[g]),
            .pend_o   (rpend_q[g])
        );

        assign rd_data[g*WIDTH +: WIDTH] = rdat_q[g];
        assign rd_pend[g]                = rpend_q[g];
    end

    // The claim is applied after the write clear so the new producer wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++)
                regs_q[r] <= (r < NCONST) ? const_val(r) : '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs_q[wr_addr] <= wr_data;
                pend_q[wr_addr] <= 1'b0;
            end
            if (cl_ok)
                pend_q[claim_addr] <= 1'b1;
            cnt_q   <= cnt_d;
            stall_q <= |(rd_en & rpend_d);
        end
    end

    assign stall    = stall_q;
    assign pend_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: BYPASS=1 and BYPASS=0 instances share stimulus,
// a reference model queues expected outputs that are checked after each edge.

module tb_regfile_scoreboard;
    localparam int W = 16, N = 64, R = 4, AW = 6;

    logic            clk, reset;
    logic [R-1:0]    rd_en;
    logic [R*AW-1:0] rd_addr;
    logic            wr_en, claim_en;
    logic [AW-1:0]   wr_addr, claim_addr;
    logic [W-1:0]    wr_data;

    logic [R*W-1:0] d1, d0;
    logic [R-1:0]   p1, p0;
    logic           s1, s0;
    logic [AW:0]    c1, c0;

    regfile_scoreboard #(.WIDTH(W), .NREGS(N), .NRD(R), .NCONST(4), .BYPASS(1)) u_dut1 (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(d1), .rd_pend(p1), .stall(s1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .pend_cnt(c1));

    regfile_scoreboard #(.WIDTH(W), .NREGS(N), .NRD(R), .NCONST(4), .BYPASS(0)) u_dut0 (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(d0), .rd_pend(p0), .stall(s0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .pend_cnt(c0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [R*W-1:0] d1;
        logic [R-1:0]   p1;
        logic           s1;
        logic [R*W-1:0] d0;
        logic [R-1:0]   p0;
        logic           s0;
        logic [AW:0]    cnt;
    } exp_t;

    exp_t sbq[$];
    int   total = 0, bad = 0;

    logic [W-1:0]   m_regs [N];
    logic [N-1:0]   m_pend;
    logic [R*W-1:0] m_d1, m_d0;
    logic [R-1:0]   m_p1, m_p0;
    logic           m_s1, m_s0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < N; r++) m_regs[r] = '0;
        m_regs[1] = 16'h0001;
        m_regs[2] = 16'h8000;
        m_regs[3] = 16'hffff;
        m_pend = '0;
        m_d1 = '0; m_d0 = '0; m_p1 = '0; m_p0 = '0; m_s1 = 1'b0; m_s0 = 1'b0;
    endtask

    // Predict this edge, push, advance one clock, pop and compare.
    task automatic cyc();
        exp_t          e;
        logic [AW-1:0] a;
        logic          wok, cok, byp;
        if (!reset) model_reset();
        else begin
            wok = wr_en && (wr_addr >= 6'd4);
            cok = claim_en && (claim_addr >= 6'd4);
            for (int i = 0; i < R; i++) begin
                if (rd_en[i]) begin
                    a   = rd_addr[i*AW +: AW];
                    byp = wok && (wr_addr == a);
                    m_d1[i*W +: W] = byp ? wr_data : m_regs[a];
                    m_p1[i]        = byp ? 1'b0 : m_pend[a];
                    m_d0[i*W +: W] = m_regs[a];
                    m_p0[i]        = m_pend[a];
                end
            end
            m_s1 = |(rd_en & m_p1);
            m_s0 = |(rd_en & m_p0);
            if (wok) begin
                m_regs[wr_addr] = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (cok) m_pend[claim_addr] = 1'b1;
        end
        e.d1 = m_d1; e.p1 = m_p1; e.s1 = m_s1;
        e.d0 = m_d0; e.p0 = m_p0; e.s0 = m_s0;
        e.cnt = 7'($countones(m_pend));
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("data_byp1",  64'(d1), 64'(e.d1));
        chk("pend_byp1",  64'(p1), 64'(e.p1));
        chk("stall_byp1", 64'(s1), 64'(e.s1));
        chk("cnt_byp1",   64'(c1), 64'(e.cnt));
        chk("data_byp0",  64'(d0), 64'(e.d0));
        chk("pend_byp0",  64'(p0), 64'(e.p0));
        chk("stall_byp0", 64'(s0), 64'(e.s0));
        chk("cnt_byp0",   64'(c0), 64'(e.cnt));
    endtask

    task automatic idle();
        reset = 1'b1; rd_en = '0; wr_en = 1'b0; claim_en = 1'b0;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    task automatic claim(input logic [AW-1:0] a);
        claim_en = 1'b1; claim_addr = a;
    endtask

    initial begin
        rd_addr = '0; wr_addr = '0; wr_data = '0; claim_addr = '0;
        idle();
        reset = 1'b0;
        cyc(); cyc();

        // constants after reset
        idle(); rd(0, 0); rd(1, 1); rd(2, 2); rd(3, 3); cyc();
        chk("rst_consts", 64'(d1), 64'hffff_8000_0001_0000);
        chk("rst_pend",   64'(p1), 64'h0);
        chk("rst_stall",  64'(s1), 64'h0);

        // same-cycle write/read of r5
        idle(); wr(5, 16'h1234); rd(0, 5); cyc();
        chk("byp1_r5", 64'(d1[15:0]), 64'h1234);
        chk("byp0_r5", 64'(d0[15:0]), 64'h0000);
        idle(); rd(0, 5); cyc();
        chk("byp0_r5_next", 64'(d0[15:0]), 64'h1234);

        // writes/claims to constants are ignored
        idle(); wr(2, 16'hdead); claim(1); cyc();
        idle(); rd(1, 2); cyc();
        chk("const_r2", 64'(d1[31:16]), 64'h8000);
        chk("const_cnt", 64'(c1), 64'h0);

        // claim r10, stall, then release by write with bypass
        idle(); claim(10); cyc();
        idle(); rd(0, 10); cyc();
        chk("r10_pend",  64'(p1[0]), 64'h1);
        chk("r10_stall", 64'(s1), 64'h1);
        chk("r10_cnt",   64'(c1), 64'h1);
        idle(); wr(10, 16'h00aa); rd(0, 10); cyc();
        chk("r10_wdata", 64'(d1[15:0]), 64'h00aa);
        chk("r10_wpend", 64'(p1[0]), 64'h0);
        chk("r10_wcnt",  64'(c1), 64'h0);
        chk("r10_pend0", 64'(p0[0]), 64'h1);

        // same-cycle claim and write to r7
        idle(); claim(7); wr(7, 16'h0042); cyc();
        idle(); rd(0, 7); cyc();
        chk("r7_data", 64'(d1[15:0]), 64'h0042);
        chk("r7_pend", 64'(p1[0]), 64'h1);
        chk("r7_cnt",  64'(c1), 64'h1);
        idle(); claim(7); cyc();
        chk("r7_reclaim_cnt", 64'(c1), 64'h1);

        // claim r4..r8, then reset mid-operation
        for (int k = 4; k <= 8; k++) begin
            idle(); claim(6'(k)); cyc();
        end
        chk("claim5_cnt", 64'(c1), 64'h5);
        idle(); rd(0, 4); reset = 1'b0; cyc();
        chk("rst2_cnt",   64'(c1), 64'h0);
        chk("rst2_stall", 64'(s1), 64'h0);
        idle(); rd(0, 4); rd(1, 5); rd(2, 6); rd(3, 7); cyc();
        chk("rst2_r4_7", 64'(d1), 64'h0);
        idle(); rd(2, 8); cyc();
        chk("rst2_r8", 64'(d1[47:32]), 64'h0);

        // random mix with heavy address collisions
        for (int n = 0; n < 400; n++) begin
            idle();
            rd_en = 4'($urandom);
            for (int i = 0; i < R; i++) rd_addr[i*AW +: AW] = 6'($urandom_range(0, 15));
            wr_en = 1'($urandom); wr_addr = 6'($urandom_range(0, 15)); wr_data = 16'($urandom);
            claim_en = 1'($urandom); claim_addr = 6'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) reset = 1'b0;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
